// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame levels and parity mode.
// No logic; imported by the transmitter, its FIFO and the matching receiver.
// Ports: none.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_t;

  localparam parity_mode_t PARITY_MODE = PAR_EVEN;

  // Parity bit that makes the data+parity ones count match PARITY_MODE.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_MODE == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO, DEPTH entries, registered count; head visible combinationally on dout.
// Latency: written byte is at dout the cycle after the write when the FIFO was empty.
// Backpressure: writes while full and reads while empty are ignored.
// Ports: clk, rst_n, wr_en/din (push), rd_en/dout (pop), full, empty, count.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_wr;
  logic                 do_rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = mem[rd_ptr];

  // Pointers are AW bits wide so they wrap modulo DEPTH by themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO of bytes, each sent as start, 8 data LSB first, even parity, stop.
// Latency: write at N into empty/idle -> pop at N+1, tx low at N+2; frame is 11*CLKS_PER_BIT cycles.
// Backpressure: full blocks writes; a write while full is dropped and sets sticky overflow.
// Ports: clk, rst_n, wr_en/data_in (byte in), full, empty, overflow/clr_overflow, tx (serial), busy.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4,
  parameter int AW           = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic                 tx,
  output logic                 busy
);

  localparam int          BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q;
  logic                 pop;
  logic                 baud_end;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [AW:0]          fifo_count;

  uart_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .din   (data_in),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    if (state_q != IDLE) baud_d = baud_end ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          par_d   = calc_parity(fifo_dout);
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (baud_end) state_d = STOP;
      end
      STOP: begin
        // Chain straight into the next frame so queued bytes leave with no idle gap.
        if (baud_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            par_d   = calc_parity(fifo_dout);
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state and registered, keeping tx glitch-free
    // and making it change on the same edge as the state.
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // A dropped write wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ovf_q <= 1'b0;
    else if (wr_en && full)  ovf_q <= 1'b1;
    else if (clr_overflow)   ovf_q <= 1'b0;
  end

  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: bytes pushed into a scoreboard on accepted writes,
// a line monitor decodes frames at bit centres and compares against it.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int FRAME = 11 * CPB;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] sb[$];
  int         starts[$];
  logic       mon_en;
  logic       last_par;
  logic [7:0] last_data;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (4),
    .AW           (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .tx           (tx),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; holds wr_en across one posedge. full is registered, so
  // its value here decides whether the byte is accepted.
  task automatic drive_wr(input logic [7:0] b);
    wr_en   = 1'b1;
    data_in = b;
    if (!full) sb.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int t = 0;
    while (sb.size() > 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while (busy && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("idle", busy, 0);
  endtask

  // Line monitor: first negedge with tx low is the first cycle of the start bit;
  // bit centres follow at offsets 2, 6, 10, ... cycles.
  always begin
    logic [10:0] bits;
    logic [7:0]  exp_b;
    @(negedge clk);
    if (mon_en && rst_n && tx === 1'b0) begin
      starts.push_back(cyc);
      repeat (CPB / 2) @(negedge clk);
      bits[0] = tx;
      for (int i = 1; i < 11; i++) begin
        repeat (CPB) @(negedge clk);
        bits[i] = tx;
      end
      last_data = bits[8:1];
      last_par  = bits[9];
      chk("start_bit", bits[0], 0);
      chk("stop_bit", bits[10], 1);
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        chk("data", bits[8:1], exp_b);
        chk("parity", bits[9], ^exp_b);
      end
    end
  end

  initial begin
    int w, w1, s0, lows, gap, t;
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    data_in      = 8'h00;
    clr_overflow = 1'b0;
    mon_en       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during DATA abandons the frame.
    w = cyc;
    drive_wr(8'hA5);
    wait_cyc(w + 10);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("no_frame_after_rst", lows, 0);
    chk("empty_after_rst", empty, 1);
    sb.delete();
    starts.delete();
    mon_en = 1'b1;

    // Single byte latency and frame length.
    w = cyc;
    drive_wr(8'h55);
    chk("empty_n1", empty, 0);
    chk("tx_high_n1", tx, 1);
    @(negedge clk);
    chk("tx_fall_n2", tx, 0);
    wait_cyc(w + 1 + FRAME);
    chk("busy_last_cycle", busy, 1);
    @(negedge clk);
    chk("busy_after_frame", busy, 0);
    chk("tx_idle_after", tx, 1);
    chk("sb_after_55", sb.size(), 0);
    chk("par_55", last_par, 0);

    // Odd-weight byte.
    drive_wr(8'h07);
    drain(200);
    chk("par_07", last_par, 1);
    chk("data_07", last_data, 8'h07);
    wait_idle(100);

    // Back-to-back burst, overflow handling, write at the pop edge.
    starts.delete();
    w1 = cyc;
    for (int i = 1; i <= 5; i++) drive_wr(8'(i));
    chk("full_after_burst", full, 1);
    drive_wr(8'hFF);
    chk("ovf_set", overflow, 1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_clr", overflow, 0);
    clr_overflow = 1'b1;
    drive_wr(8'hFF);
    clr_overflow = 1'b0;
    chk("ovf_set_beats_clr", overflow, 1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_clr2", overflow, 0);

    s0 = w1 + 2;
    wait_cyc(s0 + FRAME - 1);
    chk("full_before_pop", full, 1);
    drive_wr(8'hEE);
    chk("ovf_full_pop", overflow, 1);
    chk("count3_after_pop", full, 0);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    wait_cyc(s0 + 2 * FRAME - 1);
    chk("full_before_pop2", full, 0);
    drive_wr(8'h66);
    chk("wr_pop_keeps3", full, 0);
    drive_wr(8'h77);
    chk("full_count4", full, 1);
    chk("ovf_no_spurious", overflow, 0);

    gap = 0;
    t   = 0;
    while (sb.size() > 0 && t < 8 * FRAME) begin
      @(negedge clk);
      t++;
      if (!busy) gap++;
    end
    chk("burst_drain", sb.size(), 0);
    chk("busy_no_gap", gap, 0);
    chk("frames", starts.size(), 7);
    if (starts.size() == 7) begin
      chk("first_start", starts[0], s0);
      for (int i = 1; i < 7; i++) chk("frame_spacing", starts[i] - starts[i-1], FRAME);
    end
    wait_idle(100);
    chk("final_empty", empty, 1);
    chk("final_tx", tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Byte-buffered UART transmitter: accepts bytes over a write handshake into a small FIFO and serialises each byte onto tx.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- The frame is bit-exact with what uart_receiver expects.
- Sits between the byte-producing logic and the serial line. It replaces the unbuffered transmitter where back-to-back bytes must go out without producer stalls.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
- DEPTH, 4, FIFO entries (power of two, >=2).
- AW, 2, FIFO address width = log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe; data_in is captured when wr_en=1 and full=0.
- data_in  input  8  byte to transmit.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- overflow  output  1  sticky; set when wr_en=1 while full=1.
- clr_overflow  input  1  synchronous clear of overflow.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress or FIFO non-empty.

Behaviour:
- Reset (rst_n=0, asynchronous): tx=1, full=0, empty=1, overflow=0, busy=0.
  - FIFO pointers, count, bit counter and baud counter are set to 0; FSM goes to IDLE.
  - A frame in flight when reset asserts is abandoned; tx returns high immediately.
- FIFO: registered count of width AW+1.
  - full = (count==DEPTH); empty = (count==0); both derived from registered count only.
  - Write accepted iff wr_en & ~full.
  - Write while full is dropped and sets overflow, even if a pop occurs the same cycle.
  - A simultaneous accepted write and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- overflow: set has priority over clr_overflow in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If ~empty: pop head into the shift register, compute parity = XOR of the 8 bits, clear baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit index 7 completes, go to PARITY.
  - PARITY: tx=parity (even parity: total ones over data+parity is even) for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if ~empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1; a bit boundary is the cycle the counter equals CLKS_PER_BIT-1.
- Latency:
  - Write accepted at cycle N into an empty FIFO with FSM in IDLE: empty deasserts at N+1, pop occurs at N+1, tx falls at N+2.
  - Frame length is exactly 11*CLKS_PER_BIT cycles.
- tx is driven from a register (glitch-free).
- busy = (state!=IDLE) | ~empty; busy is registered-equivalent, since both terms are registered.
- Writes are always accepted when not full, in any FSM state.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - Frame constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
  - Parity mode (even). The receiver reads the same package.
- One sub-module: uart_fifo (parameterised DEPTH/AW; wr_en/rd_en/din/dout/full/empty/count). The FSM and shifter stay in the top module.

Test Plan (CLKS_PER_BIT=4, DEPTH=4):
- Reset mid-frame: write 0xA5, assert rst_n=0 during DATA -> tx=1 immediately; after release empty=1, busy=0, no further frame.
- Single byte: write 0x55 at cycle N -> tx falls at N+2. Line sampled at bit centres reads 0,1,0,1,0,1,0,1,0,0(parity),1; total 44 cycles low-to-idle.
- Parity odd-weight: write 0x07 -> parity bit 1. Looped into uart_receiver: data_out=0x07, parity_error=0.
- Back-to-back: write 0x01,0x02,0x03,0x04 on consecutive cycles -> full=1 after 4th accept (assuming none popped yet, else after next). Four frames with STOP followed directly by START, no idle cycles; busy stays 1 throughout.
- Overflow: fill FIFO, hold wr_en with 0xFF while full -> byte dropped, overflow=1 sticky. clr_overflow clears it; wr_en+full+clr_overflow in the same cycle keeps overflow=1.
- Simultaneous write/pop: with count=4 at the STOP end, assert wr_en -> write dropped and overflow set. With count=3, write+pop in the same cycle leaves count=3.
